// File: rtl/mem_uart.sv
// mem_uart: memory-mapped 8N1 UART transmitter with a TX FIFO on the valid/ready bus.
// Define MEM_UART_RX_EN to compile in the optional receiver.
module mem_uart #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter logic [15:0] DIV_MIN     = 16'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t   state, state_next;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty, push, push_ok, pop, load, tx_next, bit_end;
  logic [15:0] div, div_eff, div_lat, bit_timer;
  logic [7:0]  shifter;
  logic [2:0]  bit_cnt;
  logic        overflow, access, wr, rd;
  logic [1:0]  sel;
  logic [31:0] rdata_next;
  logic        rx_valid, rx_overrun;
  logic [7:0]  rx_data;
  logic        unused;

  assign unused     = ^{uart_rx, mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};
  assign sel        = mem_addr[3:2];
  assign access     = mem_valid & ~mem_ready;
  assign wr         = access & (|mem_wstrb);
  assign rd         = access & ~(|mem_wstrb);
  assign push       = wr && (sel == 2'd0) && mem_wstrb[0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push & (~fifo_full | pop);
  assign div_eff    = (div < DIV_MIN) ? DIV_MIN : div;
  assign bit_end    = (bit_timer == div_lat);

  always_comb begin
    rdata_next = '0;
    case (sel)
      2'd0:    rdata_next[7:0]  = rx_data;
      2'd1:    rdata_next[5:0]  = {rx_overrun, rx_valid, overflow, state != IDLE, fifo_empty, fifo_full};
      2'd2:    rdata_next[15:0] = div;
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      div       <= DEFAULT_DIV;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      mem_ready <= access;
      mem_rdata <= rd ? rdata_next : '0;
      if (wr && sel == 2'd2) begin
        if (mem_wstrb[0]) div[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) div[15:8] <= mem_wdata[15:8];
      end
      if (push && !push_ok)
        overflow <= 1'b1;
      else if (wr && sel == 2'd1 && mem_wstrb[0] && mem_wdata[3])
        overflow <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    pop        = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop = 1'b1; load = 1'b1; state_next = START; tx_next = 1'b0;
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin state_next = DATA; tx_next = shifter[0]; end
      end
      DATA: begin
        tx_next = shifter[0];
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin state_next = STOP; tx_next = 1'b1; end
          else tx_next = shifter[1];
        end
      end
      STOP: if (bit_end) begin
        if (!fifo_empty) begin
          pop = 1'b1; load = 1'b1; state_next = START; tx_next = 1'b0;
        end else state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // uart_tx carries the level chosen for the state being entered, so it stays registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_tx   <= 1'b1;
      bit_timer <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
      div_lat   <= '0;
    end else begin
      uart_tx <= tx_next;
      if (load) begin
        shifter   <= fifo_mem[rd_ptr[AW-1:0]];
        div_lat   <= div_eff;
        bit_timer <= '0;
        bit_cnt   <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          bit_timer <= '0;
          if (state == DATA) begin
            shifter <= {1'b0, shifter[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else bit_timer <= bit_timer + 16'd1;
      end
    end
  end

`ifdef MEM_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state, rx_state_next;
  logic [2:0]  rx_sync;
  logic [15:0] rx_timer, rx_div;
  logic [2:0]  rx_cnt;
  logic [7:0]  rx_shift;
  logic        rx_in, rx_fall, rx_mid, rx_bit_end, rx_restart, rx_done;

  // rx_sync[1:0] is the synchroniser; rx_sync[2] holds the previous synchronised level.
  assign rx_in      = rx_sync[1];
  assign rx_fall    = rx_sync[2] & ~rx_sync[1];
  assign rx_mid     = (rx_timer == {1'b0, rx_div[15:1]});
  assign rx_bit_end = (rx_timer == rx_div);
  assign rx_restart = (rx_state == RX_START) ? rx_mid : rx_bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_done       = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
      RX_START: if (rx_mid) rx_state_next = rx_in ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_cnt == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_bit_end) begin rx_state_next = RX_IDLE; rx_done = rx_in; end
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync    <= '1;
      rx_timer   <= '0;
      rx_div     <= '0;
      rx_cnt     <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], uart_rx};
      if (rx_state == RX_IDLE) begin
        rx_timer <= '0;
        rx_div   <= div_eff;
        rx_cnt   <= '0;
      end else if (rx_restart) begin
        rx_timer <= '0;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rx_in, rx_shift[7:1]};
          rx_cnt   <= rx_cnt + 3'd1;
        end
      end else rx_timer <= rx_timer + 16'd1;
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid) rx_overrun <= 1'b1;
      end else if (rd && sel == 2'd0) rx_valid <= 1'b0;
      if (wr && sel == 2'd1 && mem_wstrb[0] && mem_wdata[5] && !(rx_done && rx_valid))
        rx_overrun <= 1'b0;
    end
  end
`else
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_data    = '0;
`endif
endmodule

// File: tb/tb_mem_uart.sv
// Self-checking bench for mem_uart: register vector table, serial frame monitor and randomized bursts.
module tb_mem_uart;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0, rst = 1'b0, mem_valid = 1'b0, mem_ready, uart_tx, uart_rx = 1'b1;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;

  int tests = 0, fails = 0;
  int unsigned cyc = 0;

  // Reference model state: bytes accepted but not yet on the line, current DIV, overflow flag.
  byte unsigned exp_q[$];
  int unsigned  starts[$];
  int unsigned  model_div = 433, frames_seen = 0;
  logic         exp_ovf = 1'b0, in_frame = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  mem_uart #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd433), .DIV_MIN(16'd3)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic int unsigned period(input int unsigned d);
    return ((d < 3) ? 3 : d) + 1;
  endfunction

  function automatic logic [31:0] model_status();
    return {26'b0, 2'b00, exp_ovf, in_frame, exp_q.size() == 0, exp_q.size() == DEPTH};
  endfunction

  // Frame monitor: every frame must be 0, 8 data bits LSB first, 1, each held period(DIV) cycles.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        int unsigned p, idx;
        byte unsigned b;
        bit ok, aborted;
        logic expbit;
        p = period(model_div);
        starts.push_back(cyc);
        in_frame = 1'b1;
        ok = 1'b1; aborted = 1'b0;
        check("frame_expected", exp_q.size() != 0, 1'b1);
        b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        for (int k = 0; k < 10 * int'(p); k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin aborted = 1'b1; break; end
          idx = k / p;
          expbit = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx-1];
          if (uart_tx !== expbit) ok = 1'b0;
        end
        in_frame = 1'b0;
        if (!aborted) begin
          frames_seen++;
          check($sformatf("frame_%02h_p%0d", b, p), ok, 1'b1);
        end
      end
    end
  end

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic [31:0] rdata);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    @(posedge clk); #1;
    check("ack_latency", mem_ready, 1'b1);
    rdata = mem_rdata;
    mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); #1;
    check("ack_single", mem_ready, 1'b0);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    bus(addr, '0, 4'b0000, r);
    check(name, r, exp);
  endtask

  task automatic write_div(input int unsigned d);
    logic [31:0] r;
    bus(32'h8, d, 4'b0011, r);
    model_div = d & 32'hFFFF;
  endtask

  task automatic write_data(input byte unsigned b);
    logic [31:0] r;
    bus(32'h0, {24'h0, b}, 4'b0001, r);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < limit) begin
      @(negedge clk); n++;
    end
    check("drain_in_time", (exp_q.size() == 0) && !in_frame, 1'b1);
    @(negedge clk);
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                         input logic [31:0] e);
    vec_t v;
    v.addr = a; v.wdata = w; v.wstrb = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); uart_rx = f[i];
      repeat (7) @(negedge clk);
    end
    repeat (16) @(negedge clk);
  endtask

  initial begin : main
    logic [31:0] r;
    int unsigned f0, acks, n, d;
    #2 rst = 1'b1;
    #1;
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    add_vec(32'h4, 32'h0,        4'b0000, 32'h0000_0002);
    add_vec(32'h8, 32'h0,        4'b0000, 32'd433);
    add_vec(32'h0, 32'h0,        4'b0000, 32'h0);
    add_vec(32'hC, 32'h0,        4'b0000, 32'h0);
    add_vec(32'h8, 32'hFFFF1234, 4'b1111, 32'h0);
    add_vec(32'h8, 32'h0,        4'b0000, 32'h0000_1234);
    add_vec(32'h8, 32'h000000CD, 4'b0001, 32'h0);
    add_vec(32'h8, 32'h0,        4'b0000, 32'h0000_12CD);
    add_vec(32'h8, 32'h0000EF00, 4'b0010, 32'h0);
    add_vec(32'h8, 32'h0,        4'b0000, 32'h0000_EFCD);
    add_vec(32'h8, 32'hFFFF0000, 4'b1100, 32'h0);
    add_vec(32'h8, 32'h0,        4'b0000, 32'h0000_EFCD);
    add_vec(32'hC, 32'hFFFFFFFF, 4'b1111, 32'h0);
    add_vec(32'hC, 32'h0,        4'b0000, 32'h0);
    add_vec(32'h4, 32'hFFFFFFFF, 4'b1111, 32'h0);
    add_vec(32'h4, 32'h0,        4'b0000, 32'h0000_0002);
    foreach (vecs[i]) begin
      bus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
      if (vecs[i].wstrb == 4'b0000) check($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // Single frame at the divisor floor.
    write_div(3);
    write_data(8'h55);
    wait_done(200);
    rd_check("single_status", 32'h4, model_status());

    // Back-to-back frames: second start bit follows the first stop bit directly.
    write_data(8'hA5);
    write_data(8'h0F);
    wait_done(300);
    check("b2b_gap", starts[$] - starts[$-1], 32'd40);

    // Master holds mem_valid one extra cycle: exactly one ack and one push.
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h81; mem_wstrb = 4'b0001;
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (i == 0) exp_q.push_back(8'h81);
      acks += mem_ready;
    end
    mem_valid = 1'b0; mem_wstrb = '0;
    check("hold_valid_acks", acks, 1);
    wait_done(200);

    // DIV below the floor, then a mid-frame DIV change applies to the next frame only.
    write_div(0);
    write_data(8'h3A);
    write_data(8'hC5);
    repeat (10) @(negedge clk);
    write_div(7);
    wait_done(400);
    check("midframe_gap", starts[$] - starts[$-1], 32'd40);
    rd_check("div_readback", 32'h8, 32'd7);

    // Overflow: one byte in the shifter, eight in the FIFO, the tenth dropped.
    write_div(100);
    f0 = frames_seen;
    for (int i = 0; i < 10; i++) write_data(byte'(8'h10 + i));
    check("ovf_model_flag", exp_ovf, 1'b1);
    rd_check("ovf_status", 32'h4, model_status());
    rd_check("ovf_status_abs", 32'h4, 32'h0000_000D);
    bus(32'h4, 32'h8, 4'b0001, r);
    exp_ovf = 1'b0;
    rd_check("ovf_cleared", 32'h4, 32'h0000_0005);
    wait_done(12000);
    check("ovf_frames", frames_seen - f0, 9);

    // Randomized bursts at random divisors, checked by the frame monitor.
    for (int burst = 0; burst < 6; burst++) begin
      d = $urandom_range(0, 9);
      write_div(d);
      n = $urandom_range(1, 5);
      for (int i = 0; i < int'(n); i++) begin
        write_data(byte'($urandom));
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_done(3000);
      rd_check("rand_status", 32'h4, model_status());
    end

`ifdef MEM_UART_RX_EN
    write_div(7);
    send_rx(8'h3C);
    rd_check("rx_status_valid", 32'h4, 32'h0000_0012);
    rd_check("rx_data", 32'h0, 32'h0000_003C);
    rd_check("rx_status_clear", 32'h4, 32'h0000_0002);
    @(negedge clk); uart_rx = 1'b0;
    repeat (2) @(negedge clk); uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd_check("rx_glitch", 32'h4, 32'h0000_0002);
    send_rx(8'hA1);
    send_rx(8'h5E);
    rd_check("rx_overrun", 32'h4, 32'h0000_0032);
    rd_check("rx_data2", 32'h0, 32'h0000_005E);
    bus(32'h4, 32'h20, 4'b0001, r);
    rd_check("rx_overrun_clear", 32'h4, 32'h0000_0002);
`else
    rd_check("norx_data", 32'h0, 32'h0);
`endif

    // Asynchronous reset in the middle of a frame discards the FIFO.
    write_div(3);
    write_data(8'h00);
    write_data(8'h11);
    write_data(8'h22);
    repeat (15) @(posedge clk);
    #3;
    check("pre_reset_tx", uart_tx, 1'b0);
    rst = 1'b1;
    #1;
    check("async_reset_tx", uart_tx, 1'b1);
    exp_q.delete();
    exp_ovf = 1'b0;
    model_div = 433;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = frames_seen;
    rd_check("post_reset_status", 32'h4, 32'h0000_0002);
    rd_check("post_reset_div", 32'h8, 32'd433);
    repeat (60) @(negedge clk);
    check("post_reset_no_frames", frames_seen - f0, 0);
    check("post_reset_tx_idle", uart_tx, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
